// File: rtl/eq_sample_serializer.sv
// eq_sample_serializer: output stage of the 8-band equalizer.
// Each full-precision y_in sample is rounded and saturated to N bits at the
// moment it is accepted, then buffered in a small FIFO. The mono sample is
// sent on a left-justified serial link (sclk/ws/sd), once in the left slot
// and again in the right slot.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | link quiet (sclk/ws/sd low); start a frame when ena=1 and FIFO holds data
// RUN   | frames stream back-to-back; ena and FIFO level are looked at on the last clk of a frame
module eq_sample_serializer #(
   parameter int N          = 16,
   parameter int IN_W       = 32,
   parameter int SHIFT      = 15,
   parameter int FIFO_DEPTH = 4,
   parameter int BCLK_DIV   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] y_in,
   output logic            sclk,
   output logic            ws,
   output logic            sd,
   output logic            sat_pulse,
   output logic            underrun
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int DIV_W = $clog2(2 * BCLK_DIV);
   localparam int BIT_W = $clog2(2 * N);
   localparam int Q_W   = IN_W + 1 - SHIFT;

   localparam logic [DIV_W-1:0] DIV_TOP  = DIV_W'(2 * BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(BCLK_DIV);
   localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(2 * N - 1);
   localparam logic [BIT_W-1:0] BIT_MID  = BIT_W'(N);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   localparam logic signed [IN_W:0]  RND_HALF = (IN_W + 1)'(1) << (SHIFT - 1);
   localparam logic signed [Q_W-1:0] Q_MAX    = {{(Q_W - N + 1){1'b0}}, {(N - 1){1'b1}}};
   localparam logic signed [Q_W-1:0] Q_MIN    = {{(Q_W - N + 1){1'b1}}, {(N - 1){1'b0}}};

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t              state;
   logic [DIV_W-1:0]    div_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [N-1:0]        smp;
   logic [N-1:0]        shreg;

   logic signed [IN_W:0]  rnd_sum;
   logic signed [Q_W-1:0] rnd_q;
   logic [N-1:0]          conv_word;
   logic                  conv_sat;

   logic [N-1:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    count_nxt;
   logic [N-1:0]        head;
   logic                push;
   logic                pop;
   logic                frame_end;

   assign push      = in_valid && in_ready;
   assign head      = mem[rd_ptr];
   assign frame_end = (state == S_RUN) && (div_cnt == '0) && (bit_cnt == '0);
   assign pop       = ena && (count != '0) && ((state == S_IDLE) || frame_end);

   // Round half up at the SHIFT boundary, then clamp into the N-bit signed range.
   always_comb begin
      rnd_sum   = $signed({y_in[IN_W-1], y_in}) + RND_HALF;
      rnd_q     = $signed(rnd_sum[IN_W:SHIFT]);
      conv_word = rnd_q[N-1:0];
      conv_sat  = 1'b0;
      if (rnd_q > Q_MAX) begin
         conv_word = {1'b0, {(N - 1){1'b1}}};
         conv_sat  = 1'b1;
      end else if (rnd_q < Q_MIN) begin
         conv_word = {1'b1, {(N - 1){1'b0}}};
         conv_sat  = 1'b1;
      end
   end

   // FIFO occupancy for the next cycle; push and pop together leave it unchanged.
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   // Sample storage is written only on an accepted push and needs no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= conv_word;
   end

   // FIFO pointers, registered ready and the saturation flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         in_ready  <= 1'b0;
         sat_pulse <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count     <= count_nxt;
         in_ready  <= (count_nxt < CNT_FULL);
         sat_pulse <= push && conv_sat;
      end
   end

   // Frame sequencer: bit-clock divider, bit counter and serial shifter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         smp      <= '0;
         shreg    <= '0;
         sclk     <= 1'b0;
         ws       <= 1'b0;
         sd       <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= 1'b0;
         case (state)
            S_IDLE: begin
               sclk <= 1'b0;
               ws   <= 1'b0;
               sd   <= 1'b0;
               if (pop) begin
                  state   <= S_RUN;
                  div_cnt <= DIV_TOP;
                  bit_cnt <= BIT_TOP;
                  smp     <= head;
                  sd      <= head[N-1];
                  shreg   <= {head[N-2:0], 1'b0};
               end
            end
            S_RUN: begin
               if (div_cnt == '0) begin
                  div_cnt <= DIV_TOP;
                  sclk    <= 1'b0;
                  if (bit_cnt == '0) begin
                     if (!ena) begin
                        state <= S_IDLE;
                        ws    <= 1'b0;
                        sd    <= 1'b0;
                     end else begin
                        bit_cnt <= BIT_TOP;
                        ws      <= 1'b0;
                        if (pop) begin
                           smp   <= head;
                           sd    <= head[N-1];
                           shreg <= {head[N-2:0], 1'b0};
                        end else begin
                           // nothing buffered: keep the link clocking with a silent frame
                           smp      <= '0;
                           sd       <= 1'b0;
                           shreg    <= '0;
                           underrun <= 1'b1;
                        end
                     end
                  end else begin
                     bit_cnt <= bit_cnt - BIT_W'(1);
                     if (bit_cnt == BIT_MID) begin
                        // right slot repeats the same sample from its MSB
                        ws    <= 1'b1;
                        sd    <= smp[N-1];
                        shreg <= {smp[N-2:0], 1'b0};
                     end else begin
                        sd    <= shreg[N-1];
                        shreg <= {shreg[N-2:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
                  sclk    <= (div_cnt <= DIV_HI);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eq_sample_serializer.sv
`timescale 1ns/1ps
module tb_eq_sample_serializer;
   localparam int N          = 16;
   localparam int IN_W       = 32;
   localparam int SHIFT      = 15;
   localparam int FIFO_DEPTH = 4;
   localparam int BCLK_DIV   = 2;
   localparam int LIM        = 3000;

   logic            clk = 1'b0;
   logic            rst;
   logic            ena;
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] y_in;
   logic            sclk;
   logic            ws;
   logic            sd;
   logic            sat_pulse;
   logic            underrun;

   int cyc     = 0;
   int n_pass  = 0;
   int n_total = 0;
   int und_cnt = 0;

   logic [16:0] exp_q[$];
   bit          sat_q[$];

   eq_sample_serializer #(
      .N(N), .IN_W(IN_W), .SHIFT(SHIFT), .FIFO_DEPTH(FIFO_DEPTH), .BCLK_DIV(BCLK_DIV)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
      .y_in(y_in), .sclk(sclk), .ws(ws), .sd(sd), .sat_pulse(sat_pulse), .underrun(underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
   endtask

   task automatic note_fail(input string name, input int act);
      n_total++;
      $display("FAIL %s: got %0d, expected no such event (cycle %0d)", name, act, cyc);
   endtask

   // Monitor: decodes serial slots and checks sat/underrun pulses against the scoreboard.
   initial begin
      logic        prev_sclk;
      int          nb;
      logic [15:0] shw;
      logic        slot_ws;
      logic        sat_pend;
      logic        sat_exp;
      prev_sclk = 1'b0; nb = 0; shw = '0; slot_ws = 1'b0; sat_pend = 1'b0; sat_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            nb = 0; prev_sclk = 1'b0; sat_pend = 1'b0;
         end else begin
            if (sat_pend) chk("sat_pulse", 32'(sat_pulse), 32'(sat_exp));
            else if (sat_pulse) note_fail("sat_pulse_spurious", 1);
            sat_pend = in_valid && in_ready;
            if (sat_pend) sat_exp = (sat_q.size() > 0) ? sat_q.pop_front() : 1'b0;
            if (underrun) begin
               und_cnt++;
               chk("underrun_at_frame_start", 32'(ws | sclk | (nb != 0)), 32'd0);
            end
            if (sclk && !prev_sclk) begin
               if (nb == 0) slot_ws = ws;
               else if (ws !== slot_ws) chk("ws_stable_in_slot", 32'(ws), 32'(slot_ws));
               shw = {shw[14:0], sd};
               nb++;
               if (nb == N) begin
                  nb = 0;
                  if (exp_q.size() == 0) note_fail("unexpected_slot", int'({slot_ws, shw}));
                  else chk("slot_ws_word", 32'({slot_ws, shw}), 32'(exp_q.pop_front()));
               end
            end
            prev_sclk = sclk;
         end
      end
   end

   // Present one sample and hold it until accepted; caller is at posedge+2.
   task automatic push(input logic [IN_W-1:0] y, input logic [N-1:0] w, input bit s,
                       output int acc_cyc);
      bit rdy;
      int n;
      n = 0;
      exp_q.push_back({1'b0, w});
      exp_q.push_back({1'b1, w});
      sat_q.push_back(s);
      in_valid = 1'b1;
      y_in     = y;
      do begin
         rdy = in_ready;
         @(posedge clk); #2;
         n++;
      end while (!rdy && n < LIM);
      if (!rdy) note_fail("push_timeout", n);
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   // Let queued slots stream, drop ena during the final frame, then confirm the link is quiet.
   task automatic drain();
      int   n;
      logic hi;
      n = 0; hi = 1'b0;
      while (exp_q.size() > 1 && n < LIM) begin @(posedge clk); #2; n++; end
      ena = 1'b0;
      while (exp_q.size() > 0 && n < LIM) begin @(posedge clk); #2; n++; end
      if (n >= LIM) note_fail("drain_timeout", exp_q.size());
      repeat (4) begin @(posedge clk); #2; end
      repeat (12) begin hi |= sclk | ws | sd; @(posedge clk); #2; end
      chk("idle_outputs_held_low", 32'(hi), 32'd0);
   endtask

   task automatic wait_level(input bit sel_ws, input logic v, output int c);
      int n;
      n = 0;
      while (((sel_ws ? ws : sclk) !== v) && n < LIM) begin @(posedge clk); #2; n++; end
      if (n >= LIM) note_fail("wait_level_timeout", n);
      c = cyc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   ta, t, tc, te, t5, ub;
      logic hi;
      rst = 1'b0; ena = 1'b0; in_valid = 1'b0; y_in = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_ws", 32'(ws), 32'd0);
      chk("rst_sd", 32'(sd), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_sat_pulse", 32'(sat_pulse), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      rst = 1'b1;
      chk("in_ready_at_release", 32'(in_ready), 32'd0);
      @(posedge clk); #2;
      chk("in_ready_first_edge", 32'(in_ready), 32'd1);

      // rounding
      ub = und_cnt; ena = 1'b1;
      push(32'h0000_4000, 16'h0001, 1'b0, t);
      push(32'hFFFF_C000, 16'h0000, 1'b0, t);
      push(32'h0001_7FFF, 16'h0003, 1'b0, t);
      drain();
      chk("rounding_no_underrun", 32'(und_cnt - ub), 32'd0);

      // saturation
      ub = und_cnt; ena = 1'b1;
      push(32'h4000_0000, 16'h7FFF, 1'b1, t);
      push(32'hC000_0000, 16'h8000, 1'b0, t);
      push(32'h8000_0000, 16'h8000, 1'b1, t);
      drain();
      chk("saturation_no_underrun", 32'(und_cnt - ub), 32'd0);

      // frame timing
      ub = und_cnt; ena = 1'b1;
      push(32'h5555_0000, 16'h7FFF, 1'b1, ta);
      push(32'h0000_8000, 16'h0001, 1'b0, t);
      chk("sclk_low_before_first_bit", 32'(sclk), 32'd0);
      wait_level(1'b0, 1'b1, tc);
      chk("first_sclk_rise_cycle", 32'(tc - ta), 32'd3);
      wait_level(1'b1, 1'b1, tc);
      chk("ws_rise_frame1", 32'(tc - ta), 32'd65);
      wait_level(1'b1, 1'b0, tc);
      chk("ws_fall_frame2_start", 32'(tc - ta), 32'd129);
      wait_level(1'b1, 1'b1, tc);
      chk("ws_rise_frame2", 32'(tc - ta), 32'd193);
      drain();
      chk("frames_no_underrun", 32'(und_cnt - ub), 32'd0);

      // backpressure
      ub = und_cnt; ena = 1'b0;
      push(32'h091A_0000, 16'h1234, 1'b0, t);
      push(32'h0787_8000, 16'h0F0F, 1'b0, t);
      push(32'hD5E6_8000, 16'hABCD, 1'b0, t);
      push(32'h0000_0000, 16'h0000, 1'b0, t);
      chk("in_ready_low_when_full", 32'(in_ready), 32'd0);
      te = 0;
      fork
         push(32'h3FFF_3FFF, 16'h7FFE, 1'b0, t5);
         begin
            repeat (4) begin @(posedge clk); #2; end
            chk("fifth_held_in_ready", 32'(in_ready), 32'd0);
            ena = 1'b1;
            te  = cyc;
         end
      join
      chk("fifth_accept_after_pop", 32'(t5 - te), 32'd2);
      drain();
      chk("backpressure_no_underrun", 32'(und_cnt - ub), 32'd0);

      // underrun then stop
      ub = und_cnt; ena = 1'b1;
      push(32'h0012_3456, 16'h0024, 1'b0, t);
      exp_q.push_back(17'h0_0000);
      exp_q.push_back(17'h1_0000);
      drain();
      chk("underrun_pulsed_once", 32'(und_cnt - ub), 32'd1);

      // async reset mid-frame at bit 9, second half of the bit period
      ub = und_cnt; ena = 1'b1;
      push(32'hFFFF_8000, 16'hFFFF, 1'b0, ta);
      push(32'h0000_8000, 16'h0001, 1'b0, t);
      push(32'h0001_0000, 16'h0002, 1'b0, t);
      while (cyc < ta + 39) begin @(posedge clk); #2; end
      chk("bit9_sclk_high", 32'(sclk), 32'd1);
      chk("bit9_sd", 32'(sd), 32'd1);
      #1;
      rst = 1'b0;
      exp_q.delete();
      sat_q.delete();
      #1;
      chk("async_rst_sclk", 32'(sclk), 32'd0);
      chk("async_rst_ws", 32'(ws), 32'd0);
      chk("async_rst_sd", 32'(sd), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      chk("in_ready_at_release2", 32'(in_ready), 32'd0);
      @(posedge clk); #2;
      chk("in_ready_after_release2", 32'(in_ready), 32'd1);
      hi = 1'b0;
      repeat (20) begin @(posedge clk); #2; hi |= sclk; end
      chk("fifo_empty_after_reset", 32'(hi), 32'd0);
      push(32'h1234_5678, 16'h2469, 1'b0, t);
      drain();
      chk("reset_no_underrun", 32'(und_cnt - ub), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
